nbcac_tx_arbiter: RTL and testbench

NBCAC_TX_ARBITER -- requirements
Module: nbcac_tx_arbiter

---
 rtl/nbcac_pkg.sv | 28 ++
 rtl/nbcac_17di_encoder_core.sv | 46 ++++
 rtl/nbcac_tx_arbiter.sv | 166 ++++++++++++++++
 tb/tb_nbcac_tx_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nbcac_pkg.sv
// nbcac_pkg
//   Shared definitions for the NBCAC transmit arbiter:
//   - arb_state_e   : arbiter FSM state (IDLE = no owner, BURST = owner locked)
//   - DATA_W        : requester payload width (17)
//   - CODE_W        : NBCAC codeword width (24)
//   - MAX_BURST_LIMIT : largest burst length the arbiter supports
//   - FIB_W         : Fibonacci weights F(2)..F(24) used by the encoder
package nbcac_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int MAX_BURST_LIMIT = 16;
  localparam int DATA_W          = 17;
  localparam int CODE_W          = 24;

  // Weight of transition position k is F(k+1); the largest (F(24)) is
  // below 2**16 and the full set can represent any 16-bit value.
  localparam logic [15:0] FIB_W [1:23] = '{
    16'd1,     16'd2,     16'd3,     16'd5,     16'd8,     16'd13,
    16'd21,    16'd34,    16'd55,    16'd89,    16'd144,   16'd233,
    16'd377,   16'd610,   16'd987,   16'd1597,  16'd2584,  16'd4181,
    16'd6765,  16'd10946, 16'd17711, 16'd28657, 16'd46368
  };

endpackage

// File: rtl/nbcac_17di_encoder_core.sv
// nbcac_17di_encoder_core
//   Combinational 17-bit to 24-bit crosstalk-avoidance encoder. The
//   codeword never contains the patterns 010 or 101 on adjacent wires.
//   Ports:
//     v [16:0] : data word in
//     d [24:1] : codeword out
//   Encoding: v[15:0] is written in Zeckendorf form over F(2)..F(24),
//   which gives a 23-bit transition vector with no two adjacent ones.
//   d[1] carries v[16]; each higher wire is the previous wire toggled
//   by its transition bit, so no two neighbouring wire pairs both toggle.
module nbcac_17di_encoder_core
  import nbcac_pkg::*;
(
  input  logic [DATA_W-1:0] v,
  output logic [CODE_W:1]   d
);

  logic [15:0]     rem;
  logic [23:1]     trans;
  logic [CODE_W:1] code;

  // Greedy Fibonacci decomposition from the largest weight down; the
  // greedy choice never selects two neighbouring weights.
  always_comb begin
    rem   = v[15:0];
    trans = '0;
    for (int k = 23; k >= 1; k--) begin
      if (rem >= FIB_W[k]) begin
        trans[k] = 1'b1;
        rem      = rem - FIB_W[k];
      end
    end
  end

  // Integrate the transition vector into wire levels.
  always_comb begin
    code    = '0;
    code[1] = v[16];
    for (int k = 1; k <= 23; k++) begin
      code[k+1] = code[k] ^ trans[k];
    end
  end

  assign d = code;

endmodule

// File: rtl/nbcac_tx_arbiter.sv
// nbcac_tx_arbiter
//   Two-requester burst arbiter in front of a single shared NBCAC encoder
//   with a one-entry registered output slot.
//   Ports:
//     clock                  : rising-edge clock
//     rst                    : synchronous active-high reset
//     reqN_valid/data/ready  : requester N word handshake (N = 0, 1)
//     out_code [24:1]        : registered codeword
//     out_src                : requester that produced out_code
//     out_valid / out_ready  : output slot handshake
//   MAX_BURST : words one requester may send per grant (1..16).
module nbcac_tx_arbiter
  import nbcac_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [CODE_W:1]   out_code,
  output logic              out_src,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int BURST_LEN = (MAX_BURST < 1) ? 1 :
                             (MAX_BURST > MAX_BURST_LIMIT) ? MAX_BURST_LIMIT : MAX_BURST;
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BURST_LEN);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [CODE_W:1]   out_code_q, out_code_d;
  logic              out_src_q, out_src_d;
  logic              out_valid_q, out_valid_d;

  logic              slot_free;
  logic              grant;
  logic              grant_active;
  logic              owner_valid;
  logic              accept;
  logic [DATA_W-1:0] enc_in;
  logic [CODE_W:1]   enc_out;

  // Arbitration. A burst that ran to full length leaves burst_cnt at
  // BURST_LEN; the IDLE cycle that follows grants nobody, which is the
  // one-cycle switch-over. An early release leaves the count short, so
  // the next IDLE cycle arbitrates straight away.
  always_comb begin
    slot_free    = ~out_valid_q | out_ready;
    grant        = 1'b0;
    grant_active = 1'b0;
    owner_valid  = owner_q ? req1_valid : req0_valid;
    case (state_q)
      IDLE: begin
        if (burst_cnt_q != FULL_CNT) begin
          if (req0_valid && req1_valid) begin
            grant        = ~last_owner_q;
            grant_active = 1'b1;
          end else if (req0_valid) begin
            grant        = 1'b0;
            grant_active = 1'b1;
          end else if (req1_valid) begin
            grant        = 1'b1;
            grant_active = 1'b1;
          end
        end
      end
      BURST: begin
        grant        = owner_q;
        grant_active = 1'b1;
      end
      default: ;
    endcase
    req0_ready = grant_active & ~grant & slot_free & ~rst;
    req1_ready = grant_active &  grant & slot_free & ~rst;
    accept     = (req0_ready & req0_valid) | (req1_ready & req1_valid);
  end

  assign enc_in = grant ? req1_data : req0_data;

  nbcac_17di_encoder_core u_encoder (
    .v (enc_in),
    .d (enc_out)
  );

  // Output slot and FSM next state. The codeword and source are only
  // reloaded on an accept so the bus never toggles without new data.
  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    out_code_d   = out_code_q;
    out_src_d    = out_src_q;
    out_valid_d  = out_valid_q;

    if (accept) begin
      out_code_d  = enc_out;
      out_src_d   = grant;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (burst_cnt_q == FULL_CNT) begin
          burst_cnt_d = '0;
        end else if (accept) begin
          last_owner_d = grant;
          if (BURST_LEN > 1) begin
            state_d     = BURST;
            owner_d     = grant;
            burst_cnt_d = CNT_W'(1);
          end
        end
      end
      BURST: begin
        // A stalled but still-valid owner keeps the bus.
        if (!owner_valid) begin
          state_d = IDLE;
        end else if (accept) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
          if (burst_cnt_q + CNT_W'(1) == FULL_CNT) begin
            state_d = IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= IDLE;
      burst_cnt_q  <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      out_code_q   <= '0;
      out_src_q    <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      out_code_q   <= out_code_d;
      out_src_q    <= out_src_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_code  = out_code_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_nbcac_tx_arbiter.sv
// tb_nbcac_tx_arbiter
//   Self-checking bench for nbcac_tx_arbiter with MAX_BURST = 4. Inputs are
//   driven on the falling edge and outputs are compared 1 ns later against
//   a behavioural model of the arbitration rules. Codewords are judged by
//   decoding them back to data and by the no-010/no-101 wire property.
module tb_nbcac_tx_arbiter;

  localparam int MAX_BURST = 4;

  logic        clock = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [16:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [24:1] out_code;
  logic        out_src, out_valid, out_ready;

  always #5 clock = ~clock;

  nbcac_tx_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clock      (clock),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_code   (out_code),
    .out_src    (out_src),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  int checks   = 0;
  int failures = 0;

  // Words each requester still has to send, and whether it offers them.
  logic [16:0] q0[$];
  logic [16:0] q1[$];
  bit          en0, en1;

  // Model: owner is -1 when nobody holds the bus; gap marks the dead
  // cycle after a full-length burst.
  int          m_owner = -1;
  int          m_sent  = 0;
  int          m_last  = 1;
  bit          m_gap   = 0;
  bit          m_ov    = 0;
  bit          m_osrc  = 0;
  logic [16:0] m_odata = 17'h0;

  int src_log[$];
  bit log_on = 0;

  // Fibonacci-weighted sum of wire-to-wire transitions, plus wire 1 as bit 16.
  function automatic int decode_word(input logic [24:1] c);
    int a = 1;
    int b = 1;
    int sum = 0;
    int tmp;
    for (int k = 1; k <= 23; k++) begin
      if (c[k] ^ c[k+1]) sum += b;
      tmp = a + b;
      a   = b;
      b   = tmp;
    end
    return sum + (c[1] ? 65536 : 0);
  endfunction

  function automatic bit pattern_free(input logic [24:1] c);
    for (int k = 1; k <= 22; k++) begin
      if ((c[k] ^ c[k+1]) && (c[k+1] ^ c[k+2])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic applyStimulus(input bit r, input bit ordy);
    int          g;
    bit          sf, acc;
    bit          v [2];
    logic [16:0] dat [2];
    @(negedge clock);
    rst        = r;
    out_ready  = ordy;
    req0_valid = en0 && (q0.size() > 0);
    req0_data  = (q0.size() > 0) ? q0[0] : 17'h0;
    req1_valid = en1 && (q1.size() > 0);
    req1_data  = (q1.size() > 0) ? q1[0] : 17'h0;
    #1;
    v[0] = req0_valid;  v[1] = req1_valid;
    dat[0] = req0_data; dat[1] = req1_data;
    sf = !m_ov || ordy;
    g  = -1;
    if (!r) begin
      if (m_owner >= 0)     g = m_owner;
      else if (!m_gap) begin
        if (v[0] && v[1])   g = 1 - m_last;
        else if (v[0])      g = 0;
        else if (v[1])      g = 1;
      end
    end
    acc = (g >= 0) && sf && v[g];

    checkOutput("req0_ready", req0_ready, (g == 0) && sf);
    checkOutput("req1_ready", req1_ready, (g == 1) && sf);
    checkOutput("out_valid", out_valid, m_ov);
    checkOutput("out_src", out_src, m_osrc);
    checkOutput("out_data", decode_word(out_code), {15'h0, m_odata});
    checkOutput("out_fpf", pattern_free(out_code), 1);
    if (log_on && out_valid && ordy) src_log.push_back(int'(out_src));

    if (r) begin
      m_owner = -1; m_sent = 0; m_last = 1; m_gap = 0;
      m_ov = 0; m_osrc = 0; m_odata = 17'h0;
    end else begin
      if (acc) begin
        m_odata = dat[g]; m_osrc = g[0]; m_ov = 1;
      end else if (ordy) begin
        m_ov = 0;
      end
      if (m_owner >= 0) begin
        if (!v[m_owner]) begin
          m_owner = -1;
        end else if (acc) begin
          m_sent++;
          if (m_sent == MAX_BURST) begin
            m_owner = -1; m_gap = 1;
          end
        end
      end else if (m_gap) begin
        m_gap = 0;
      end else if (acc) begin
        m_last = g;
        if (MAX_BURST > 1) begin
          m_owner = g; m_sent = 1;
        end
      end
      if (acc) begin
        if (g == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
    end
  endtask

  task automatic fillQueues(input int n0, input int n1);
    q0.delete(); q1.delete();
    for (int i = 0; i < n0; i++) q0.push_back(17'($urandom));
    for (int i = 0; i < n1; i++) q1.push_back(17'($urandom));
  endtask

  initial begin
    int pattern [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    rst = 1'b1; out_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 17'h0; req1_data = 17'h0;
    en0 = 0; en1 = 0;

    // Reset held with both requesters offering words.
    $display("[TB] reset hold");
    fillQueues(2, 2); en0 = 1; en1 = 1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1);
      checkOutput("rst_code", out_code, 0);
    end

    // Single source with corner data words.
    $display("[TB] single source");
    q0.delete(); q1.delete();
    q0.push_back(17'h00000); q0.push_back(17'h1FFFF); q0.push_back(17'h0A5A5);
    en0 = 1; en1 = 0;
    src_log.delete(); log_on = 1;
    for (int i = 0; i < 6; i++) applyStimulus(0, 1);
    log_on = 0;
    checkOutput("single_words", src_log.size(), 3);
    foreach (src_log[i]) checkOutput("single_src", src_log[i], 0);

    // Continuous contention, starting from a fresh reset.
    $display("[TB] contention");
    applyStimulus(1, 1);
    fillQueues(12, 12); en0 = 1; en1 = 1;
    src_log.delete(); log_on = 1;
    for (int i = 0; i < 14; i++) applyStimulus(0, 1);
    log_on = 0;
    checkOutput("cont_words", src_log.size() >= 10, 1);
    for (int i = 0; i < 10 && i < src_log.size(); i++)
      checkOutput("cont_src", src_log[i], pattern[i]);

    // Backpressure in the middle of a burst.
    $display("[TB] backpressure");
    applyStimulus(1, 1);
    fillQueues(8, 8);
    for (int i = 0; i < 2; i++) applyStimulus(0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1);

    // Early release by requester 1 while requester 0 waits.
    $display("[TB] early release");
    applyStimulus(1, 1);
    fillQueues(4, 2); en0 = 0; en1 = 1;
    applyStimulus(0, 1);
    en0 = 1;
    applyStimulus(0, 1);
    applyStimulus(0, 1);
    applyStimulus(0, 1);
    checkOutput("early_grant0", req0_ready, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1);

    // Reset in the middle of a burst.
    $display("[TB] reset mid-burst");
    applyStimulus(1, 1);
    fillQueues(6, 6);
    applyStimulus(0, 1);
    applyStimulus(0, 1);
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    checkOutput("midrst_valid", out_valid, 0);
    checkOutput("midrst_code", out_code, 0);
    checkOutput("midrst_grant0", req0_ready, 1);
    checkOutput("midrst_grant1", req1_ready, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1);

    // Random traffic, backpressure and occasional resets.
    $display("[TB] random traffic");
    applyStimulus(1, 1);
    q0.delete(); q1.delete();
    for (int i = 0; i < 400; i++) begin
      if (q0.size() < 4 && $urandom_range(1) == 1) q0.push_back(17'($urandom));
      if (q1.size() < 4 && $urandom_range(1) == 1) q1.push_back(17'($urandom));
      en0 = ($urandom_range(9) < 8);
      en1 = ($urandom_range(9) < 8);
      applyStimulus($urandom_range(99) == 0, $urandom_range(9) < 7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
